// File: rtl/prbs15_burst_ctrl.sv
// ---------------------------------------------------------------------------
// prbs15_burst_ctrl
//
// Sequencer for a prbs15 generator instance. On an accepted start it latches
// the configuration, loads the seed into the generator, lets it run for
// burst_len frames, freezes it for gap_len cycles between bursts, repeats for
// num_bursts bursts and then pulses done_o.
//
// Optional feature macro: PRBS_CTRL_RESEED_EN
//   defined   : every burst is preceded by a LOAD cycle (each burst replays
//               the sequence from the seed).
//   undefined : only the first burst loads; later bursts continue the LFSR
//               sequence contiguously across gaps.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_i        start request (only looked at in IDLE)
//   abort_i        abort current sequence, overrides start_i
//   seed_i         LFSR seed, latched on accepted start
//   burst_len_i    frames per burst, latched on accepted start
//   gap_len_i      frozen cycles between bursts, latched on accepted start
//   num_bursts_i   number of bursts, latched on accepted start
//   prbs_init_o    seed to prbs15.prbs_init_i
//   load_prbs_o    to prbs15.load_prbs_i (high only in LOAD)
//   freeze_o       to prbs15.freeze_i (low only in RUN)
//   frame_valid_o  prbs15.prbs_frame_o is a valid burst frame
//   burst_idx_o    0-based index of the current burst
//   busy_o         high in every state except IDLE
//   done_o         one-cycle completion pulse
//   err_cfg_o      one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module prbs15_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [14:0]      seed_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [LEN_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] num_bursts_i,
  output logic [14:0]      prbs_init_o,
  output logic             load_prbs_o,
  output logic             freeze_o,
  output logic             frame_valid_o,
  output logic [CNT_W-1:0] burst_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_cfg_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef PRBS_CTRL_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  // state entered at the start of every burst after the first
  localparam state_t ENTRY = RESEED ? S_LOAD : S_RUN;

  // registered state and latched configuration
  state_t           r_state;
  logic [14:0]      r_seed;
  logic [LEN_W-1:0] r_blen;
  logic [LEN_W-1:0] r_glen;
  logic [CNT_W-1:0] r_nb;
  logic [LEN_W-1:0] r_bcnt;   // RUN cycles left in current burst, 1 = last
  logic [LEN_W-1:0] r_gcnt;   // GAP cycles left, 1 = last
  logic [CNT_W-1:0] r_idx;
  logic             r_err;

  // next-state decode
  state_t w_next;
  logic   w_accept;
  logic   w_cfg_bad;
  logic   w_run_last;
  logic   w_gap_last;
  logic   w_more;
  logic   w_bload;
  logic   w_gload;
  logic   w_idx_inc;

  assign w_accept   = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_cfg_bad  = (seed_i == 15'd0) || (burst_len_i == '0) ||
                      (num_bursts_i == '0);
  // Down-counters loaded with the length and tested against 1, so a length
  // of all-ones never needs a wider counter.
  assign w_run_last = (r_bcnt == LEN_W'(1));
  assign w_gap_last = (r_gcnt == LEN_W'(1));
  assign w_more     = (r_idx != (r_nb - CNT_W'(1)));

  always_comb begin
    w_next    = r_state;
    w_bload   = 1'b0;
    w_gload   = 1'b0;
    w_idx_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_cfg_bad) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next  = S_RUN;
        w_bload = 1'b1;
      end
      S_RUN: begin
        if (w_run_last) begin
          if (!w_more) begin
            w_next = S_DONE;
          end else if (r_glen != '0) begin
            w_next  = S_GAP;
            w_gload = 1'b1;
          end else begin
            w_next    = ENTRY;
            w_idx_inc = 1'b1;
            // with reseed the LOAD cycle reloads the burst counter itself
            w_bload   = !RESEED;
          end
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_next    = ENTRY;
          w_idx_inc = 1'b1;
          w_bload   = !RESEED;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_seed  <= '0;
      r_blen  <= '0;
      r_glen  <= '0;
      r_nb    <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && w_cfg_bad;

      // a rejected start still latches; only LOAD consumes the values
      if (w_accept) begin
        r_seed <= seed_i;
        r_blen <= burst_len_i;
        r_glen <= gap_len_i;
        r_nb   <= num_bursts_i;
      end

      if (w_bload)                r_bcnt <= r_blen;
      else if (r_state == S_RUN)  r_bcnt <= r_bcnt - LEN_W'(1);

      if (w_gload)                r_gcnt <= r_glen;
      else if (r_state == S_GAP)  r_gcnt <= r_gcnt - LEN_W'(1);

      // index reads 0 whenever the block is idle
      if (w_next == S_IDLE)       r_idx <= '0;
      else if (w_idx_inc)         r_idx <= r_idx + CNT_W'(1);
    end
  end

  // Moore outputs
  assign prbs_init_o   = r_seed;
  assign load_prbs_o   = (r_state == S_LOAD);
  assign freeze_o      = (r_state != S_RUN);
  assign frame_valid_o = (r_state == S_RUN);
  assign burst_idx_o   = r_idx;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign err_cfg_o     = r_err;

endmodule

// File: tb/tb_prbs15_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs15_burst_ctrl
//
// Drives prbs15_burst_ctrl with directed and random configurations and
// compares every cycle against a reference built as a per-cycle expectation
// queue computed from the sequence rules. A small stand-in prbs15 generator
// (x^15 + x^14 + 1, shift left) is driven by the controller outputs; its
// frames must match frames computed from the seed for each burst position.
// ---------------------------------------------------------------------------
module tb_prbs15_burst_ctrl;
  localparam int LEN_W = 10;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [14:0]      seed_i = '0;
  logic [LEN_W-1:0] burst_len_i = '0;
  logic [LEN_W-1:0] gap_len_i = '0;
  logic [CNT_W-1:0] num_bursts_i = '0;
  logic [14:0]      prbs_init_o;
  logic             load_prbs_o, freeze_o, frame_valid_o, busy_o, done_o, err_cfg_o;
  logic [CNT_W-1:0] burst_idx_o;

  always #5 clk = ~clk;

  prbs15_burst_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .seed_i(seed_i), .burst_len_i(burst_len_i), .gap_len_i(gap_len_i),
    .num_bursts_i(num_bursts_i), .prbs_init_o(prbs_init_o),
    .load_prbs_o(load_prbs_o), .freeze_o(freeze_o),
    .frame_valid_o(frame_valid_o), .burst_idx_o(burst_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_cfg_o(err_cfg_o)
  );

`ifdef PRBS_CTRL_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  function automatic logic [14:0] nxt(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // stand-in generator: loads on a rising load edge, advances when unfrozen
  logic [14:0] m_lfsr = '0;
  logic        m_ld_d = 1'b0;
  always @(posedge clk) begin
    m_ld_d <= load_prbs_o;
    if (load_prbs_o && !m_ld_d) m_lfsr <= prbs_init_o;
    else if (!freeze_o)         m_lfsr <= nxt(m_lfsr);
  end

  typedef struct {
    bit          ld;
    bit          fz;
    bit          vl;
    bit          dn;
    int          idx;
    logic [14:0] frm;
  } cyc_t;

  cyc_t        q[$];       // q[0] is the expectation for the current cycle
  logic [14:0] e_init = '0;
  bit          e_err = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input bit ld, input bit fz, input bit vl, input bit dn,
                      input int idx, input logic [14:0] frm);
    cyc_t c;
    c.ld = ld; c.fz = fz; c.vl = vl; c.dn = dn; c.idx = idx; c.frm = frm;
    q.push_back(c);
  endtask

  // whole accepted sequence: LOAD, bursts with gaps, DONE
  task automatic build();
    int          n = int'(num_bursts_i);
    int          l = int'(burst_len_i);
    int          g = int'(gap_len_i);
    logic [14:0] s = seed_i;
    for (int b = 0; b < n; b++) begin
      if (b == 0 || RESEED) begin
        push(1, 1, 0, 0, b, '0);
        s = seed_i;
      end
      for (int k = 0; k < l; k++) begin
        push(0, 0, 1, 0, b, s);
        s = nxt(s);
      end
      if (b < n - 1)
        for (int k = 0; k < g; k++) push(0, 1, 0, 0, b, '0);
    end
    push(0, 1, 0, 1, n - 1, '0);
  endtask

  // advance the reference by one clock edge using the inputs seen at that edge
  task automatic step();
    e_err = 1'b0;
    if (rst_i) begin
      q.delete();
      e_init = '0;
    end else if (q.size() != 0) begin
      if (abort_i) q.delete();
      else void'(q.pop_front());
    end else if (start_i && !abort_i) begin
      e_init = seed_i;
      if (seed_i == 0 || burst_len_i == 0 || num_bursts_i == 0) e_err = 1'b1;
      else build();
    end
  endtask

  task automatic cmp();
    cyc_t e;
    bit   bz = (q.size() != 0);
    if (bz) e = q[0];
    else begin
      e.ld = 0; e.fz = 1; e.vl = 0; e.dn = 0; e.idx = 0; e.frm = '0;
    end
    chk("load",  load_prbs_o,   e.ld);
    chk("freeze", freeze_o,     e.fz);
    chk("valid", frame_valid_o, e.vl);
    chk("done",  done_o,        e.dn);
    chk("idx",   burst_idx_o,   e.idx);
    chk("busy",  busy_o,        bz);
    chk("err",   err_cfg_o,     e_err);
    chk("init",  prbs_init_o,   e_init);
    if (e.vl) chk("frame", m_lfsr, e.frm);
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    cmp();
  endtask

  task automatic cfg(input int s, input int l, input int g, input int n);
    seed_i       = 15'(s);
    burst_len_i  = LEN_W'(l);
    gap_len_i    = LEN_W'(g);
    num_bursts_i = CNT_W'(n);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 5000) begin
      cyc();
      k++;
    end
    chk("drain_timeout", q.size(), 0);
    cyc();
  endtask

  task automatic run(input int s, input int l, input int g, input int n);
    cfg(s, l, g, n);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    drain();
  endtask

  initial begin
    // reset
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();

    // directed sequences
    run(1, 4, 2, 2);
    run(1, 4, 0, 2);
    run(0, 4, 2, 2);
    run(1, 0, 2, 2);
    run(1, 4, 2, 0);
    run(15'h7fff, 1, 0, 255);
    run(15'h1234, (1 << LEN_W) - 1, (1 << LEN_W) - 1, 2);

    // abort during 3rd RUN cycle, then restart
    cfg(1, 8, 2, 2);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc(); cyc(); cyc();
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    cyc();
    run(1, 3, 1, 2);

    // start held through a whole N=1 sequence and a bit beyond
    cfg(15'h0abc, 3, 1, 1);
    start_i = 1'b1;
    repeat (12) cyc();
    start_i = 1'b0;
    drain();

    // reset mid-GAP
    cfg(5, 2, 5, 2);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (4) cyc();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    cyc();

    // random sequences with sporadic abort / reset / held start
    for (int it = 0; it < 120; it++) begin
      bit hold = ($urandom_range(0, 3) == 0);
      int len  = $urandom_range(5, 60);
      cfg(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 32767),
          $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int c = 0; c < len; c++) begin
        start_i = (c == 0) || (hold && $urandom_range(0, 1) == 1);
        abort_i = ($urandom_range(0, 49) == 0);
        rst_i   = ($urandom_range(0, 149) == 0);
        cyc();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      rst_i   = 1'b0;
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
